// File: rtl/keypad_debounce_pkg.sv
// Shared types and constants for the keypad debouncer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package keypad_pkg;

  localparam int CNT_W = 8;

  localparam logic [3:0] KEY_NONE = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_res_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/keypad_debounce_frame_accum.sv
// Collapses the scanner strobes of one scan frame into NONE / SINGLE(k) / MULTI.
// Latency: result valid combinationally in the SCAN_START cycle that closes the frame.
// Backpressure: none; the scanner free-runs and every frame is evaluated.
module keypad_frame_accum
  import keypad_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCAN_START,
  input  logic       PRESS,
  input  logic [3:0] DATA,
  output logic       frame_done,
  output frame_res_t frame_res,
  output logic [3:0] frame_code
);

  frame_res_t acc_res;
  logic [3:0] acc_code;
  logic       frame_open;

  // The SCAN_START sample belongs to the new frame, so the closing result
  // is the accumulator contents as they stand before this edge.
  assign frame_done = SCAN_START & frame_open;
  assign frame_res  = acc_res;
  assign frame_code = acc_code;

  // Accumulate PRESS strobes; reseed on SCAN_START. Cycles before the first
  // SCAN_START after reset never reach the FSM because frame_open is still 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_res    <= FR_NONE;
      acc_code   <= KEY_NONE;
      frame_open <= 1'b0;
    end else if (SCAN_START) begin
      frame_open <= 1'b1;
      if (PRESS) begin
        acc_res  <= FR_SINGLE;
        acc_code <= DATA;
      end else begin
        acc_res  <= FR_NONE;
        acc_code <= KEY_NONE;
      end
    end else if (PRESS) begin
      if (acc_res == FR_NONE) begin
        acc_res  <= FR_SINGLE;
        acc_code <= DATA;
      end else if (acc_res == FR_SINGLE && DATA != acc_code) begin
        acc_res <= FR_MULTI;
      end
    end
  end

endmodule

// File: rtl/keypad_debounce.sv
// Frame-based keypad debouncer: one registered key event per physical press.
// Latency: event visible the cycle after the SCAN_START that closes the confirming frame.
// Backpressure: valid/ack; a new commit overwrites an unacked event and flags OVERRUN.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int RELEASE_FRAMES  = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCAN_START,
  input  logic       PRESS,
  input  logic [3:0] DATA,
  input  logic       KEY_ACK,
  output logic       KEY_VALID,
  output logic [3:0] KEY_CODE,
  output logic       KEY_HELD,
  output logic       OVERRUN
);

  localparam logic [CNT_W-1:0] DEB_N = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] REL_N = CNT_W'(RELEASE_FRAMES);

  logic             frame_done;
  frame_res_t       frame_res;
  logic [3:0]       frame_code;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] rcnt, rcnt_nxt, rcnt_inc;
  logic [3:0]       cand, cand_nxt;
  logic             commit;
  logic [3:0]       commit_code;

  keypad_frame_accum u_accum (
    .CLK        (CLK),
    .RST        (RST),
    .SCAN_START (SCAN_START),
    .PRESS      (PRESS),
    .DATA       (DATA),
    .frame_done (frame_done),
    .frame_res  (frame_res),
    .frame_code (frame_code)
  );

  assign cnt_inc  = sat_inc(cnt);
  assign rcnt_inc = sat_inc(rcnt);

  // Debounce FSM: advances only when a frame closes.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rcnt_nxt    = rcnt;
    cand_nxt    = cand;
    commit      = 1'b0;
    commit_code = cand;
    if (frame_done) begin
      case (state)
        ST_IDLE: begin
          if (frame_res == FR_SINGLE) begin
            if (DEBOUNCE_FRAMES == 1) begin
              commit      = 1'b1;
              commit_code = frame_code;
              cnt_nxt     = '0;
              state_nxt   = ST_HELD;
            end else begin
              cand_nxt  = frame_code;
              cnt_nxt   = CNT_W'(1);
              state_nxt = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (frame_res == FR_SINGLE) begin
            if (frame_code == cand) begin
              if (cnt_inc >= DEB_N) begin
                commit    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_HELD;
              end else begin
                cnt_nxt = cnt_inc;
              end
            end else begin
              // Key changed mid-confirm: restart with the new candidate.
              cand_nxt = frame_code;
              cnt_nxt  = CNT_W'(1);
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (frame_res == FR_NONE) begin
            if (RELEASE_FRAMES == 1) begin
              state_nxt = ST_IDLE;
            end else begin
              rcnt_nxt  = CNT_W'(1);
              state_nxt = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (frame_res == FR_NONE) begin
            if (rcnt_inc >= REL_N) begin
              rcnt_nxt  = '0;
              state_nxt = ST_IDLE;
            end else begin
              rcnt_nxt = rcnt_inc;
            end
          end else begin
            rcnt_nxt  = '0;
            state_nxt = ST_HELD;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state, counters and candidate registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rcnt  <= '0;
      cand  <= KEY_NONE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rcnt  <= rcnt_nxt;
      cand  <= cand_nxt;
    end
  end

  // Event handshake: a commit always wins over a same-cycle ack; an unacked
  // event that gets replaced sets the sticky OVERRUN flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      KEY_VALID <= 1'b0;
      KEY_CODE  <= KEY_NONE;
      KEY_HELD  <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      KEY_HELD <= (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE);
      if (commit) begin
        KEY_CODE  <= commit_code;
        KEY_VALID <= 1'b1;
        if (KEY_VALID) begin
          OVERRUN <= ~KEY_ACK;
        end
      end else if (KEY_VALID && KEY_ACK) begin
        KEY_VALID <= 1'b0;
        OVERRUN   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce with 3-cycle scan frames.
// Each frame: cycle a carries SCAN_START, cycles b/c may carry PRESS.
// Outputs are sampled 1 time unit after the rising edge.
module tb_keypad_debounce;
  import keypad_pkg::*;

  logic       CLK;
  logic       RST;
  logic       SCAN_START;
  logic       PRESS;
  logic [3:0] DATA;
  logic       KEY_ACK;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       KEY_HELD;
  logic       OVERRUN;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs packed as {valid, held, overrun, code[3:0]}.
  typedef struct {
    logic       pb;
    logic [3:0] kb;
    logic       pc;
    logic [3:0] kc;
    logic [2:0] ack;    // [2]=cycle a, [1]=cycle b, [0]=cycle c
    logic [6:0] exp_a;  // after the SCAN_START cycle
    logic [6:0] exp_c;  // after the last cycle of the frame
  } frame_vec_t;

  frame_vec_t vecs[$];

  keypad_debounce #(
    .DEBOUNCE_FRAMES (4),
    .RELEASE_FRAMES  (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SCAN_START (SCAN_START),
    .PRESS      (PRESS),
    .DATA       (DATA),
    .KEY_ACK    (KEY_ACK),
    .KEY_VALID  (KEY_VALID),
    .KEY_CODE   (KEY_CODE),
    .KEY_HELD   (KEY_HELD),
    .OVERRUN    (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic frame_vec_t mk(input int pb, input int kb, input int pc, input int kc,
                                    input int ack,
                                    input int av, input int ah, input int ao, input int ac,
                                    input int cv, input int ch, input int co, input int cc);
    frame_vec_t v;
    v.pb    = 1'(pb);
    v.kb    = 4'(kb);
    v.pc    = 1'(pc);
    v.kc    = 4'(kc);
    v.ack   = 3'(ack);
    v.exp_a = {1'(av), 1'(ah), 1'(ao), 4'(ac)};
    v.exp_c = {1'(cv), 1'(ch), 1'(co), 4'(cc)};
    return v;
  endfunction

  task automatic add(input int pb, input int kb, input int pc, input int kc, input int ack,
                     input int av, input int ah, input int ao, input int ac,
                     input int cv, input int ch, input int co, input int cc);
    vecs.push_back(mk(pb, kb, pc, kc, ack, av, ah, ao, ac, cv, ch, co, cc));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [6:0] exp);
    logic [6:0] got;
    got = {KEY_VALID, KEY_HELD, OVERRUN, KEY_CODE};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got valid=%b held=%b ovr=%b code=%0d, expected valid=%b held=%b ovr=%b code=%0d",
               name, idx, got[6], got[5], got[4], got[3:0], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic run_frame(input frame_vec_t v, input int idx);
    SCAN_START = 1'b1; PRESS = 1'b0; DATA = KEY_NONE; KEY_ACK = v.ack[2];
    tick();
    check("frame_close", idx, v.exp_a);
    SCAN_START = 1'b0; PRESS = v.pb; DATA = v.pb ? v.kb : KEY_NONE; KEY_ACK = v.ack[1];
    tick();
    PRESS = v.pc; DATA = v.pc ? v.kc : KEY_NONE; KEY_ACK = v.ack[0];
    tick();
    check("frame_end", idx, v.exp_c);
    PRESS = 1'b0; DATA = KEY_NONE; KEY_ACK = 1'b0;
  endtask

  initial begin
    RST = 1'b1; SCAN_START = 1'b0; PRESS = 1'b0; DATA = KEY_NONE; KEY_ACK = 1'b0;

    // Clean press: key 5 for 6 frames, then 5 empty frames; ack mid-release.
    for (int i = 0; i < 4; i++) add(1,5,0,0,0,  0,0,0,13,  0,0,0,13);
    add(1,5,0,0,0,      1,1,0,5,   1,1,0,5);
    add(1,5,0,0,0,      1,1,0,5,   1,1,0,5);
    add(0,0,0,0,0,      1,1,0,5,   1,1,0,5);
    add(0,0,0,0,3'b010, 1,1,0,5,   0,1,0,5);
    add(0,0,0,0,0,      0,1,0,5,   0,1,0,5);
    add(0,0,0,0,0,      0,1,0,5,   0,1,0,5);
    add(0,0,0,0,0,      0,0,0,5,   0,0,0,5);
    // Bounce: key 8 present/absent/present x4.
    add(1,8,0,0,0,      0,0,0,5,   0,0,0,5);
    add(0,0,0,0,0,      0,0,0,5,   0,0,0,5);
    for (int i = 0; i < 4; i++) add(1,8,0,0,0,  0,0,0,5,  0,0,0,5);
    add(0,0,0,0,3'b010, 1,1,0,8,   0,1,0,8);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,  0,1,0,8,  0,1,0,8);
    add(0,0,0,0,0,      0,0,0,8,   0,0,0,8);
    // Ghosting aborts confirm; 2,2 then 7 restarts the candidate.
    add(1,2,0,0,0,      0,0,0,8,   0,0,0,8);
    add(1,2,1,5,0,      0,0,0,8,   0,0,0,8);
    add(1,2,0,0,0,      0,0,0,8,   0,0,0,8);
    add(1,2,0,0,0,      0,0,0,8,   0,0,0,8);
    add(1,7,0,0,0,      0,0,0,8,   0,0,0,8);
    add(1,7,0,0,0,      0,0,0,8,   0,0,0,8);
    add(1,7,0,0,0,      0,0,0,8,   0,0,0,8);
    add(1,7,1,7,0,      0,0,0,8,   0,0,0,8);
    add(1,7,0,0,3'b001, 1,1,0,7,   0,1,0,7);
    // Overrun: key 1 committed and left pending, then key 11 replaces it.
    for (int i = 0; i < 4; i++) add(0,0,0,0,0,  0,1,0,7,  0,1,0,7);
    add(1,1,0,0,0,      0,0,0,7,   0,0,0,7);
    for (int i = 0; i < 3; i++) add(1,1,0,0,0,  0,0,0,7,  0,0,0,7);
    add(0,0,0,0,0,      1,1,0,1,   1,1,0,1);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,  1,1,0,1,  1,1,0,1);
    add(1,11,0,0,0,     1,0,0,1,   1,0,0,1);
    for (int i = 0; i < 3; i++) add(1,11,0,0,0, 1,0,0,1,  1,0,0,1);
    add(1,11,0,0,3'b001, 1,1,1,11, 0,1,0,11);
    // Different key while held: no new event.
    add(1,4,0,0,0,      0,1,0,11,  0,1,0,11);
    add(1,4,0,0,0,      0,1,0,11,  0,1,0,11);
    for (int i = 0; i < 4; i++) add(0,0,0,0,0,  0,1,0,11, 0,1,0,11);
    // Same-cycle commit and ack: code 3 pending, ack on the commit cycle of 0.
    add(1,3,0,0,0,      0,0,0,11,  0,0,0,11);
    for (int i = 0; i < 3; i++) add(1,3,0,0,0,  0,0,0,11, 0,0,0,11);
    add(0,0,0,0,0,      1,1,0,3,   1,1,0,3);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,  1,1,0,3,  1,1,0,3);
    add(1,0,0,0,0,      1,0,0,3,   1,0,0,3);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0,  1,0,0,3,  1,0,0,3);
    add(0,0,0,0,3'b100, 1,1,0,0,   1,1,0,0);
    add(0,0,0,0,3'b010, 1,1,0,0,   0,1,0,0);
    // Ack while nothing is pending is ignored.
    add(0,0,0,0,3'b010, 0,1,0,0,   0,1,0,0);

    // Reset state.
    tick();
    tick();
    check("reset_state", 0, {1'b0, 1'b0, 1'b0, KEY_NONE});
    RST = 1'b0;

    // Partial frame before the first SCAN_START must be ignored.
    PRESS = 1'b1; DATA = 4'd5;
    tick();
    tick();
    PRESS = 1'b0; DATA = KEY_NONE;

    foreach (vecs[i]) run_frame(vecs[i], i);

    // Reset mid-CONFIRM: outputs return to reset values.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("reset_held_state", 1, {1'b0, 1'b0, 1'b0, KEY_NONE});
    for (int i = 0; i < 4; i++) run_frame(mk(1,9,0,0,0, 0,0,0,13, 0,0,0,13), 100 + i);
    // cnt=3 now; RST coincides with the SCAN_START that would commit.
    SCAN_START = 1'b1; PRESS = 1'b1; DATA = 4'd9; RST = 1'b1;
    tick();
    RST = 1'b0; SCAN_START = 1'b0;
    check("reset_beats_commit", 2, {1'b0, 1'b0, 1'b0, KEY_NONE});
    tick();
    PRESS = 1'b0; DATA = KEY_NONE;
    // Four more full frames are needed before the event appears.
    for (int i = 0; i < 4; i++) run_frame(mk(1,9,0,0,0, 0,0,0,13, 0,0,0,13), 200 + i);
    run_frame(mk(0,0,0,0,0, 1,1,0,9, 1,1,0,9), 204);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_debounce.md
Name: keypad_debounce

Overview:
- Sits directly downstream of the 3-column keypad scanner FSM. Consumes its per-cycle PRESS/DATA strobe and its column-C phase output, used as the frame marker.
- Groups scanner cycles into scan frames and debounces across frames.
- Emits exactly one registered key event per physical press, held with a valid/ack handshake for the MCU input port/interrupt logic.

Parameters:
- DEBOUNCE_FRAMES, 4, consecutive identical single-key frames required to accept a press; legal range 1..255.
- RELEASE_FRAMES, 4, consecutive empty frames required to accept a release; legal range 1..255.

Ports:
- CLK  in  1  system clock, all logic on posedge
- RST  in  1  synchronous, active-high reset
- SCAN_START  in  1  high during the first column (C) cycle of each scan frame
- PRESS  in  1  scanner key-detected strobe for the current column
- DATA  in  4  scanner key code (0-11 valid; 13 = none)
- KEY_ACK  in  1  consumer acknowledge, sampled only while KEY_VALID=1
- KEY_VALID  out  1  debounced key event pending
- KEY_CODE  out  4  code of the pending/last event
- KEY_HELD  out  1  a key is currently accepted as held down
- OVERRUN  out  1  sticky: an event was overwritten before it was acknowledged

Behaviour:
- Reset values: KEY_VALID=0, KEY_CODE=13, KEY_HELD=0, OVERRUN=0, FSM=IDLE, counters=0, frame accumulator cleared, frame_open=0.
- RST has priority over every other input in the same cycle, including mid-frame and mid-debounce.

Frame accumulation:
- A frame spans from one SCAN_START cycle to the cycle before the next SCAN_START.
- In a SCAN_START cycle:
  - The previous frame closes and is evaluated, but only if frame_open=1.
  - A new frame opens, seeded with this cycle's sample. frame_open is then set to 1.
- The first partial frame after reset is discarded.
- Frame result:
  - NONE: no PRESS in the frame.
  - SINGLE(k): one or more PRESS cycles, all with DATA=k.
  - MULTI: PRESS cycles carrying two or more distinct codes.
- Frame length is not checked; any gap between SCAN_START pulses is legal.

FSM (updates only on frame close):
- IDLE:
  - SINGLE(k) with DEBOUNCE_FRAMES=1 -> commit k, go to HELD.
  - SINGLE(k) otherwise -> cand=k, cnt=1, go to CONFIRM.
  - NONE or MULTI -> stay in IDLE.
- CONFIRM:
  - SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_FRAMES, commit cand and go to HELD.
  - SINGLE(j), j≠cand -> cand=j, cnt=1, stay in CONFIRM.
  - NONE or MULTI -> IDLE.
- HELD:
  - NONE with RELEASE_FRAMES=1 -> IDLE.
  - NONE otherwise -> rcnt=1, go to RELEASE.
  - SINGLE or MULTI -> stay in HELD. A different key while held produces no new event.
- RELEASE:
  - NONE -> rcnt+1. When rcnt reaches RELEASE_FRAMES, go to IDLE.
  - SINGLE or MULTI -> HELD.
- KEY_HELD = (state is HELD or RELEASE), registered.
- Counters are 8-bit and saturate; they cannot wrap for legal parameters.

Commit and handshake:
- Latency: a commit happens in the closing SCAN_START cycle. KEY_VALID=1 and KEY_CODE=k appear the following cycle.
- KEY_VALID=1 and KEY_ACK=1 with no commit that cycle -> KEY_VALID=0 and OVERRUN=0 the next cycle. KEY_CODE keeps its value.
- Commit with KEY_VALID=0 -> load the code and set KEY_VALID.
- Commit with KEY_VALID=1 and no ACK -> KEY_CODE takes the new code, KEY_VALID stays 1, OVERRUN is set.
- Commit and ACK in the same cycle -> the commit wins: new code, KEY_VALID stays 1, OVERRUN=0 (the old event was consumed).
- KEY_ACK while KEY_VALID=0 is ignored.

Decomposition:
- keypad_pkg holds:
  - state typedef: IDLE, CONFIRM, HELD, RELEASE.
  - frame-result typedef: NONE, SINGLE, MULTI.
  - constants: KEY_NONE=13, KEY_STAR=10, KEY_HASH=11, CNT_W=8.
- One sub-module: keypad_frame_accum.
  - Inputs: SCAN_START, PRESS, DATA.
  - Outputs: a one-cycle frame_done pulse, the frame result and the frame code.
- The top level holds the FSM, counters and handshake logic.

Test Plan:
- Clean press: DEBOUNCE=4, RELEASE=4, SCAN_START every 3rd cycle, key 5 for 6 frames then released for 5 frames -> exactly one KEY_VALID pulse train with KEY_CODE=5. It rises 1 cycle after the 4th full frame closes. KEY_HELD falls after the 4th empty frame.
- Bounce: key 8 pattern present/absent/present/present/present/present (frames) -> no event until 4 consecutive present frames; a single event with code 8.
- Ghosting and change: a frame with codes 2 and 5 aborts CONFIRM to IDLE. SINGLE(2) twice then SINGLE(7) restarts the candidate, and the event carries code 7.
- Overrun: commit key 1, no ACK, release 4 frames, press key 11 for 4 frames -> KEY_CODE=11 and OVERRUN=1. KEY_ACK then clears both KEY_VALID and OVERRUN the next cycle.
- Same-cycle commit and ACK: with code 3 pending, assert KEY_ACK on the commit cycle of code 0 -> KEY_VALID stays 1, KEY_CODE=0, OVERRUN=0.
- Reset mid-CONFIRM (cnt=3): assert RST for 1 cycle -> all outputs at reset values. The first partial frame is discarded, and 4 further full frames are needed to commit.
